// File: rtl/perf_pkg.sv
// Shared types and default widths for the performance-monitoring slice
// (transaction trackers and the counter bank they feed).
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RESP,
    HOLD
  } trk_state_t;

  localparam int unsigned LAT_W_DEF         = 16;
  localparam int unsigned HIT_LAT_DEF       = 0;
  localparam bit          HOLD_ON_STALL_DEF = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous load.
//   clk, rst  : clock, synchronous active-high reset (q -> 0)
//   load      : load load_val (has priority over inc)
//   load_val  : value to load
//   inc       : increment by one, sticking at all-ones
//   q         : current count
//   at_max    : q is all-ones (further increments are ignored)
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         at_max
);

  assign at_max = (q == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (inc && !at_max) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/mem_req_event_tracker.sv
// Per-port request/response tracker. Turns raw read/write/resp/stall levels
// of one cache or memory port into single-cycle event pulses for the
// performance counter bank, plus per-transaction and maximum latency.
//   clk, rst        : clock, synchronous active-high reset
//   clr             : clear max_latency only
//   req_read/write  : port request levels
//   resp            : port response
//   consumer_stall  : owning pipeline stage is stalled
//   evt_read/write  : transaction accepted (both may fire for one transaction)
//   evt_hit/miss    : completion within / beyond HIT_LAT cycles of accept
//   evt_done        : completion (always with exactly one of hit/miss)
//   done_latency    : latency of last completed transaction (held)
//   max_latency     : largest done_latency since rst or clr
//   busy            : transaction outstanding or holding for stall release
module mem_req_event_tracker
  import perf_pkg::*;
#(
  parameter int unsigned LAT_W         = LAT_W_DEF,
  parameter int unsigned HIT_LAT       = HIT_LAT_DEF,
  parameter bit          HOLD_ON_STALL = HOLD_ON_STALL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             req_read,
  input  logic             req_write,
  input  logic             resp,
  input  logic             consumer_stall,
  output logic             evt_read,
  output logic             evt_write,
  output logic             evt_hit,
  output logic             evt_miss,
  output logic             evt_done,
  output logic [LAT_W-1:0] done_latency,
  output logic [LAT_W-1:0] max_latency,
  output logic             busy
);

  // Hit threshold on the completed latency, one bit wider so HIT_LAT+1 fits.
  localparam logic [LAT_W:0] HIT_LIM = (LAT_W + 1)'(HIT_LAT + 1);

  trk_state_t       state_q, state_d;
  logic             accept, complete, lat_load, lat_inc;
  logic             lat_at_max, is_hit;
  logic [LAT_W-1:0] lat_q, done_val;
  trk_state_t       after_done;

  sat_counter #(.W(LAT_W)) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (lat_load),
    .load_val (LAT_W'(1)),
    .inc      (lat_inc),
    .q        (lat_q),
    .at_max   (lat_at_max)
  );

  assign after_done = (HOLD_ON_STALL && consumer_stall) ? HOLD : IDLE;
  assign is_hit     = ({1'b0, done_val} <= HIT_LIM);

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    lat_load = 1'b0;
    lat_inc  = 1'b0;
    done_val = '0;
    unique case (state_q)
      IDLE: begin
        if (req_read || req_write) begin
          accept   = 1'b1;
          lat_load = 1'b1;
          if (resp) begin
            complete = 1'b1;
            done_val = LAT_W'(1);
            state_d  = after_done;
          end else begin
            state_d  = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (resp) begin
          complete = 1'b1;
          done_val = lat_at_max ? lat_q : lat_q + LAT_W'(1);
          state_d  = after_done;
        end else begin
          lat_inc  = 1'b1;
        end
      end
      HOLD: begin
        if (!consumer_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      evt_read     <= 1'b0;
      evt_write    <= 1'b0;
      evt_hit      <= 1'b0;
      evt_miss     <= 1'b0;
      evt_done     <= 1'b0;
      done_latency <= '0;
      max_latency  <= '0;
    end else begin
      state_q   <= state_d;
      evt_read  <= accept & req_read;
      evt_write <= accept & req_write;
      evt_done  <= complete;
      evt_hit   <= complete & is_hit;
      evt_miss  <= complete & ~is_hit;
      if (complete) done_latency <= done_val;
      // clr discards the old maximum but never the latency completing now.
      if (complete) begin
        if (clr || (done_val > max_latency)) max_latency <= done_val;
      end else if (clr) begin
        max_latency <= '0;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_req_event_tracker.sv
module tb_mem_req_event_tracker;
  localparam int N = 3;
  localparam int unsigned LW [N] = '{16, 16, 4};
  localparam int unsigned HL [N] = '{0, 1, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, clr = 1'b0, req_read = 1'b0, req_write = 1'b0;
  logic resp = 1'b0, consumer_stall = 1'b0;

  logic        o_rd [N], o_wr [N], o_hit [N], o_miss [N], o_done [N], o_busy [N];
  logic [15:0] o_dl [N], o_mx [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [LW[g]-1:0] dl, mx;
    mem_req_event_tracker #(
      .LAT_W         (LW[g]),
      .HIT_LAT       (HL[g]),
      .HOLD_ON_STALL (1'b1)
    ) dut (
      .clk            (clk),
      .rst            (rst),
      .clr            (clr),
      .req_read       (req_read),
      .req_write      (req_write),
      .resp           (resp),
      .consumer_stall (consumer_stall),
      .evt_read       (o_rd[g]),
      .evt_write      (o_wr[g]),
      .evt_hit        (o_hit[g]),
      .evt_miss       (o_miss[g]),
      .evt_done       (o_done[g]),
      .done_latency   (dl),
      .max_latency    (mx),
      .busy           (o_busy[g])
    );
    assign o_dl[g] = 16'(dl);
    assign o_mx[g] = 16'(mx);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Transaction-level reference: an outstanding flag with its accept cycle,
  // and a stall-hold flag; latency is plain cycle arithmetic, clipped per DUT.
  bit m_out = 0, m_hold = 0;
  int m_start = 0, cyc = 0;
  bit e_rd, e_wr, e_done, e_busy;
  bit e_hit [N], e_miss [N];
  int e_dl [N], e_mx [N];

  task automatic model_step();
    bit fin = 0;
    int raw = 0;
    e_rd = 0; e_wr = 0; e_done = 0;
    for (int k = 0; k < N; k++) begin e_hit[k] = 0; e_miss[k] = 0; end
    if (rst) begin
      m_out = 0; m_hold = 0;
      for (int k = 0; k < N; k++) begin e_dl[k] = 0; e_mx[k] = 0; end
    end else begin
      if (m_hold) begin
        if (!consumer_stall) m_hold = 0;
      end else if (m_out) begin
        if (resp) begin fin = 1; raw = cyc - m_start + 1; end
      end else if (req_read || req_write) begin
        e_rd = req_read; e_wr = req_write; m_start = cyc;
        if (resp) begin fin = 1; raw = 1; end
        else m_out = 1;
      end
      if (fin) begin
        m_out = 0; m_hold = consumer_stall; e_done = 1;
        for (int k = 0; k < N; k++) begin
          int sat = (1 << LW[k]) - 1;
          int d = (raw > sat) ? sat : raw;
          e_dl[k] = d;
          e_hit[k] = (d <= int'(HL[k]) + 1);
          e_miss[k] = !e_hit[k];
          e_mx[k] = (clr || d > e_mx[k]) ? d : e_mx[k];
        end
      end else if (clr) begin
        for (int k = 0; k < N; k++) e_mx[k] = 0;
      end
    end
    e_busy = m_out || m_hold;
    cyc++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("m%0d_evt_read", k),  32'(o_rd[k]),   32'(e_rd));
      chk($sformatf("m%0d_evt_write", k), 32'(o_wr[k]),   32'(e_wr));
      chk($sformatf("m%0d_evt_hit", k),   32'(o_hit[k]),  32'(e_hit[k]));
      chk($sformatf("m%0d_evt_miss", k),  32'(o_miss[k]), 32'(e_miss[k]));
      chk($sformatf("m%0d_evt_done", k),  32'(o_done[k]), 32'(e_done));
      chk($sformatf("m%0d_done_lat", k),  32'(o_dl[k]),   32'(e_dl[k]));
      chk($sformatf("m%0d_max_lat", k),   32'(o_mx[k]),   32'(e_mx[k]));
      chk($sformatf("m%0d_busy", k),      32'(o_busy[k]), 32'(e_busy));
    end
  endtask

  task automatic drive(input bit r, input bit c, input bit rd, input bit wr,
                       input bit rs, input bit st);
    rst = r; clr = c; req_read = rd; req_write = wr; resp = rs; consumer_stall = st;
    tick();
  endtask

  typedef struct {
    bit r, c, rd, wr, rs, st;
    bit x_rd, x_wr, x_hit, x_miss, x_done, x_busy;
    int x_dl, x_mx;
  } vec_t;

  vec_t tbl [17];
  int   rd_cnt;

  initial begin
    // Hand-derived outputs of instance 0 (HIT_LAT=0) in the cycle after each row.
    //           r c rd wr rs st  rd wr hit miss done busy  dl mx
    tbl[0]  = '{1,0,0,0,0,0,  0,0,0,0,0,0,  0,0};
    tbl[1]  = '{0,0,0,0,0,0,  0,0,0,0,0,0,  0,0};
    tbl[2]  = '{0,0,1,0,1,0,  1,0,1,0,1,0,  1,1};
    tbl[3]  = '{0,0,0,0,0,0,  0,0,0,0,0,0,  1,1};
    tbl[4]  = '{0,0,0,1,0,0,  0,1,0,0,0,1,  1,1};
    tbl[5]  = '{0,0,0,1,0,0,  0,0,0,0,0,1,  1,1};
    tbl[6]  = '{0,0,0,0,1,0,  0,0,0,1,1,0,  3,3};
    tbl[7]  = '{0,0,1,1,0,0,  1,1,0,0,0,1,  3,3};
    tbl[8]  = '{0,1,0,0,1,1,  0,0,0,1,1,1,  2,2};
    tbl[9]  = '{0,0,1,0,0,1,  0,0,0,0,0,1,  2,2};
    tbl[10] = '{0,0,1,0,0,0,  0,0,0,0,0,0,  2,2};
    tbl[11] = '{0,0,1,0,0,0,  1,0,0,0,0,1,  2,2};
    tbl[12] = '{0,0,0,0,1,0,  0,0,0,1,1,0,  2,2};
    tbl[13] = '{0,1,0,0,0,0,  0,0,0,0,0,0,  2,0};
    tbl[14] = '{0,0,0,0,1,0,  0,0,0,0,0,0,  2,0};
    tbl[15] = '{0,0,1,0,0,0,  1,0,0,0,0,1,  2,0};
    tbl[16] = '{1,0,0,0,1,0,  0,0,0,0,0,0,  0,0};

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].r, tbl[i].c, tbl[i].rd, tbl[i].wr, tbl[i].rs, tbl[i].st);
      chk($sformatf("tbl%0d_evt_read", i),  32'(o_rd[0]),   32'(tbl[i].x_rd));
      chk($sformatf("tbl%0d_evt_write", i), 32'(o_wr[0]),   32'(tbl[i].x_wr));
      chk($sformatf("tbl%0d_evt_hit", i),   32'(o_hit[0]),  32'(tbl[i].x_hit));
      chk($sformatf("tbl%0d_evt_miss", i),  32'(o_miss[0]), 32'(tbl[i].x_miss));
      chk($sformatf("tbl%0d_evt_done", i),  32'(o_done[0]), 32'(tbl[i].x_done));
      chk($sformatf("tbl%0d_busy", i),      32'(o_busy[0]), 32'(tbl[i].x_busy));
      chk($sformatf("tbl%0d_done_lat", i),  32'(o_dl[0]),   32'(tbl[i].x_dl));
      chk($sformatf("tbl%0d_max_lat", i),   32'(o_mx[0]),   32'(tbl[i].x_mx));
    end

    // HIT_LAT=1: write accepted, resp next cycle -> hit at latency 2.
    drive(0,0,0,1,0,0);
    chk("h1_evt_write", 32'(o_wr[1]), 32'd1);
    drive(0,0,0,1,1,0);
    chk("h1_hit", 32'(o_hit[1]), 32'd1);
    chk("h1_done", 32'(o_done[1]), 32'd1);
    chk("h1_lat2", 32'(o_dl[1]), 32'd2);
    drive(0,0,0,0,0,0);
    // Same with resp three cycles after accept -> miss at latency 4.
    drive(0,0,0,1,0,0);
    drive(0,0,0,1,0,0);
    drive(0,0,0,1,0,0);
    drive(0,0,0,1,1,0);
    chk("h1_miss", 32'(o_miss[1]), 32'd1);
    chk("h1_lat4", 32'(o_dl[1]), 32'd4);
    chk("h1_max4", 32'(o_mx[1]), 32'd4);
    drive(0,0,0,0,0,0);

    // Stall hold: read level held through resp and stall; only one accept.
    rd_cnt = 0;
    drive(0,0,1,0,0,0); rd_cnt += int'(o_rd[0]);
    drive(0,0,1,0,0,0); rd_cnt += int'(o_rd[0]);
    drive(0,0,1,0,1,1); rd_cnt += int'(o_rd[0]);
    for (int i = 0; i < 3; i++) begin
      drive(0,0,1,0,0,1); rd_cnt += int'(o_rd[0]);
      chk("stall_busy", 32'(o_busy[0]), 32'd1);
    end
    drive(0,0,1,0,0,0); rd_cnt += int'(o_rd[0]);
    chk("stall_release_busy", 32'(o_busy[0]), 32'd0);
    chk("stall_single_read", 32'(rd_cnt), 32'd1);
    drive(0,0,1,0,0,0);
    chk("stall_reaccept", 32'(o_rd[0]), 32'd1);
    drive(0,0,0,0,1,0);
    drive(0,0,0,0,0,0);

    // Saturation on the 4-bit instance.
    drive(0,0,1,0,0,0);
    for (int i = 0; i < 19; i++) drive(0,0,0,0,0,0);
    drive(0,0,0,0,1,0);
    chk("sat_lat15", 32'(o_dl[2]), 32'd15);
    chk("sat_miss", 32'(o_miss[2]), 32'd1);
    drive(0,0,0,0,0,0);

    // rst mid-transaction drops it.
    drive(0,0,1,0,0,0);
    drive(0,0,0,0,0,0);
    drive(1,0,0,0,0,0);
    chk("rst_busy", 32'(o_busy[0]), 32'd0);
    chk("rst_max", 32'(o_mx[0]), 32'd0);
    drive(0,0,0,0,1,0);
    chk("rst_no_done", 32'(o_done[0]), 32'd0);

    // Build max 9, then clr coincident with a latency-3 completion.
    drive(0,0,1,0,0,0);
    for (int i = 0; i < 7; i++) drive(0,0,0,0,0,0);
    drive(0,0,0,0,1,0);
    chk("clr_pre_max9", 32'(o_mx[0]), 32'd9);
    drive(0,0,0,1,0,0);
    drive(0,0,0,0,0,0);
    drive(0,1,0,0,1,0);
    chk("clr_new_lat3", 32'(o_mx[0]), 32'd3);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
